mux_rr_arbiter: RTL
===================

# mux_rr_arbiter

Round-robin arbiter that shares the existing `mux` datapath between `N_SLAVES` requesters over a valid/ready handshake. It registers one grant index, drives it as the mux select, presents the winning slave's word downstream, and acknowledges only the granted slave. Downstream backpressure holds the grant. Each completed transfer rotates priority past the served slave, and back-to-back grants run with no bubble.

## Interface
- `N_SLAVES`, default 4: number of requesters; must be ≥ 2 and need not be a power of two.
- `DATA_WIDTH`, default 4: width of each slave word.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: reset; synchronous, active-high.
- `in_valid`, input, N_SLAVES: bit i = slave i has a word.
- `data`, input, DATA_WIDTH*N_SLAVES: slave i word at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_ready`, output, N_SLAVES: one-hot transfer acknowledge to the granted slave.
- `out_valid`, output, 1: `op` holds a valid word.
- `out_ready`, input, 1: downstream accepts `op`.
- `op`, output, DATA_WIDTH: granted slave's word, taken from the `mux` output.
- `sel`, output, $clog2(N_SLAVES): current grant index, i.e. the registered mux select.

## Operation
- State machine states: IDLE (no grant) and GRANT (sel valid, out_valid=1).
- Registers: state, `sel`, round-robin pointer `ptr` (range 0..N_SLAVES-1).
- Winner search: the first i with in_valid[i]=1, scanning ptr, ptr+1, …, wrapping at N_SLAVES-1 back to 0.
- IDLE:
  - If any in_valid is set: sel ← winner and state ← GRANT.
  - Otherwise remain in IDLE.
- GRANT, out_ready=0 (stall): hold state and sel.
  - Arrival of a higher-priority request does not preempt the grant.
- GRANT, out_ready=1 (handshake with slave g=sel):
  - ptr ← (g+1) mod N_SLAVES.
  - The search is rerun from (g+1) mod N_SLAVES on the current in_valid.
  - If a winner exists: sel ← winner and stay in GRANT.
  - Otherwise: state ← IDLE, and sel holds its value.
  - Slave g's in_valid is still high during its handshake cycle, so it competes at lowest priority.
- Output definitions:
  - out_valid = (state==GRANT).
  - in_ready[i] = out_valid & out_ready & (sel==i).
  - op = mux(data, sel), combinational.
- Slave obligation: a slave holds in_valid and its data stable until it sees in_ready. A bench flags any violation as a protocol error.
- Width rules:
  - The pointer increment compares against N_SLAVES-1 explicitly; it does not rely on natural overflow.
  - sel never exceeds N_SLAVES-1.

## Timing
- Reset values: state=IDLE, sel=0, ptr=0, out_valid=0, in_ready=0, op=slave 0 word.
- Latency:
  - A request sampled in IDLE at edge k gives out_valid=1 in cycle k+1.
  - A combinational path from out_ready to in_ready is allowed.
- Throughput: one transfer per cycle while requests remain pending and out_ready=1.
- Reset mid-operation: rst high at an edge forces the reset values regardless of state or handshake.
  - A handshake in that same cycle is still visible on in_ready but does not advance ptr.
  - The slave must treat the transfer as complete.
- Reset with requests pending: the first grant is issued at the first edge with rst=0, so out_valid rises one cycle after release.
- Single requester with out_ready=1 and in_valid held high: it is re-granted every cycle.

## Structure
- Shared package/header `mux_pkg`: state encoding `ST_IDLE=1'b0`, `ST_GRANT=1'b1`, and the select-width helper `SEL_W=$clog2(N_SLAVES)`.
- Sub-module: instantiate the existing `mux` (parameters N_SLAVES and DATA_WIDTH; ports data, sel, op) for the datapath. Do not re-implement the selection.
- Round-robin search as a local function (`rr_pick(req, ptr)`). No separate module is needed.

## Test plan
- Reset: rst=1 for 2 cycles with in_valid=4'b1111 → out_valid=0, in_ready=0, sel=0 during reset; first cycle after release out_valid=0; next cycle sel=0 and out_valid=1.
- Single request: in_valid=4'b0100, slave 2 word=4'hA, out_ready=1 → next cycle sel=2, op=4'hA, in_ready=4'b0100. Slave then drops valid → IDLE and out_valid=0.
- Full rotation: in_valid=4'b1111 held, out_ready=1 → sel sequence 0,1,2,3,0,1 on consecutive cycles; out_valid stays 1 with no bubble.
- Backpressure, no preemption: in_valid=4'b1010, out_ready=0 for 5 cycles → sel=1, op stable, in_ready=0. Raise in_valid[0] mid-stall → sel stays 1. Raise out_ready → handshake on slave 1, then sel=3, then sel=0.
- Non-power-of-two: N_SLAVES=3, DATA_WIDTH=8, all valid → sel sequence 0,1,2,0; sel never equals 3; ptr wraps from 2 to 0.
- Reset mid-transfer: granted sel=3 with out_ready=0, pulse rst for 1 cycle with in_valid=4'b1001 → next cycle out_valid=0; after release slave 0 wins, since ptr=0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the mux datapath and its round-robin arbiter:
// FSM state encoding and the select-width helper.
package mux_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Select width for a given number of slaves (SEL_W = $clog2(N_SLAVES)).
  function automatic int sel_w(input int n_slaves);
    return $clog2(n_slaves);
  endfunction

endpackage

// File: rtl/mux.sv
// N-way word multiplexer: presents slave sel's word on op.
module mux
  import mux_pkg::*;
#(
  parameter int N_SLAVES   = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH*N_SLAVES-1:0] data,
  input  logic [$clog2(N_SLAVES)-1:0]    sel,
  output logic [DATA_WIDTH-1:0]          op
);

  localparam int SEL_W = sel_w(N_SLAVES);

  // NOTE: op gets a default before the loop so every path assigns it and no latch is inferred.
  always_comb begin
    op = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel == SEL_W'(i)) op = data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the mux select and hands one slave's word
// downstream per valid/ready handshake, rotating priority after each transfer.
module mux_rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_SLAVES   = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_SLAVES-1:0]            in_valid,
  input  logic [DATA_WIDTH*N_SLAVES-1:0] data,
  output logic [N_SLAVES-1:0]            in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          op,
  output logic [$clog2(N_SLAVES)-1:0]    sel
);

  localparam int                SEL_W = sel_w(N_SLAVES);
  localparam logic [SEL_W-1:0]  LAST  = SEL_W'(N_SLAVES - 1);

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Explicit wrap so non-power-of-two slave counts never reach an unused index.
  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx);
    return (idx == LAST) ? '0 : idx + 1'b1;
  endfunction

  // First requester found scanning start, start+1, ... with wrap-around.
  function automatic pick_t rr_pick(input logic [N_SLAVES-1:0] req,
                                    input logic [SEL_W-1:0]    start);
    pick_t            res;
    logic [SEL_W-1:0] idx;
    res = '0;
    idx = start;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (!res.found && req[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
      idx = wrap_inc(idx);
    end
    return res;
  endfunction

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] after_grant;
  pick_t            pick_idle;
  pick_t            pick_next;

  assign after_grant = wrap_inc(sel_q);
  assign pick_idle   = rr_pick(in_valid, ptr_q);
  assign pick_next   = rr_pick(in_valid, after_grant);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_idle.found) begin
          state_d = ST_GRANT;
          sel_d   = pick_idle.idx;
        end
      end
      ST_GRANT: begin
        // A stalled grant is held; only a completed handshake re-arbitrates.
        if (out_ready) begin
          ptr_d = after_grant;
          if (pick_next.found) sel_d = pick_next.idx;
          else                 state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == ST_GRANT);
  assign sel       = sel_q;

  always_comb begin
    in_ready = '0;
    if (out_valid && out_ready) in_ready[sel_q] = 1'b1;
  end

  mux #(
    .N_SLAVES  (N_SLAVES),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .data(data),
    .sel (sel_q),
    .op  (op)
  );

endmodule
